// File: rtl/multicycle_core_if.sv
// rtl/multicycle_core_if.sv - unified instruction/data memory port (req/ack)
interface multicycle_core_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/multicycle_core.sv
// rtl/multicycle_core.sv - multi-cycle 16-bit-ISA core, FSM sequenced over one memory port
// Optional multiplier on opcode 14 when MULTICYCLE_CORE_MUL_EN is defined.
module multicycle_core #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_core_if.master   mem,
  output logic [ADDR_W-1:0]   pc,
  output logic                retire,
  output logic                halted,
  output logic                illegal
);
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state, state_next;
  logic [15:0]       ir;
  logic [DATA_W-1:0] a, b, res;
  logic [DATA_W-1:0] regs [16];

  logic [3:0] op, rd, ra, rb;
  assign op = ir[3:0];
  assign rd = ir[7:4];
  assign ra = ir[11:8];
  assign rb = ir[15:12];

  logic is_mem, is_ld, is_st, is_ctl, is_halt, is_ill;
  always_comb begin
    is_ld   = (op == 4'd8);
    is_st   = (op == 4'd9);
    is_mem  = is_ld || is_st;
    is_ctl  = (op == 4'd10) || (op == 4'd11) || (op == 4'd12);
    is_halt = (op == 4'd13);
`ifdef MULTICYCLE_CORE_MUL_EN
    is_ill  = (op == 4'd15);
`else
    is_ill  = (op == 4'd14) || (op == 4'd15);
`endif
  end

  logic [DATA_W-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (op)
      4'd0: alu_res = a + b;
      4'd1: alu_res = a - b;
      4'd2: alu_res = a & b;
      4'd3: alu_res = a | b;
      4'd4: alu_res = a ^ b;
      4'd5: alu_res = a << b[SH_W-1:0];
      4'd6: alu_res = a >> b[SH_W-1:0];
      4'd7: alu_res = {{(DATA_W-8){1'b0}}, ir[15:8]};
`ifdef MULTICYCLE_CORE_MUL_EN
      4'd14: alu_res = a * b;
`endif
      default: alu_res = '0;
    endcase
  end

  // Branch offset is the rd field, sign-extended, relative to PC+1.
  logic [ADDR_W-1:0] pc_inc, br_off, pc_next;
  logic              take;
  always_comb begin
    pc_inc  = pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    br_off  = {{(ADDR_W-4){rd[3]}}, rd};
    take    = (op == 4'd10) ? (a == b) : (a != b);
    pc_next = pc_inc;
    if (op == 4'd12)
      pc_next = a[ADDR_W-1:0];
    else if ((op == 4'd10 || op == 4'd11) && take)
      pc_next = pc_inc + br_off;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (mem.mem_ack) state_next = S_DECODE;
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        if (is_halt)               state_next = S_HALT;
        else if (is_mem)           state_next = S_MEM;
        else if (is_ctl || is_ill) state_next = S_FETCH;
        else                       state_next = S_WB;
      end
      S_MEM:    if (mem.mem_ack) state_next = is_ld ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_FETCH;
    endcase
  end

  // Reset masks the request combinationally so an abandoned transfer drops at once.
  always_comb begin
    mem.mem_req   = !reset && (state == S_FETCH || state == S_MEM);
    mem.mem_we    = !reset && (state == S_MEM) && is_st;
    mem.mem_addr  = '0;
    if (mem.mem_req)
      mem.mem_addr = (state == S_MEM) ? b[ADDR_W-1:0] : pc;
    mem.mem_wdata = mem.mem_we ? a : '0;
    halted        = (state == S_HALT);
    retire        = !reset && ((state == S_WB) ||
                               (state == S_EXEC && (is_ctl || is_ill || is_halt)) ||
                               (state == S_MEM && is_st && mem.mem_ack));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= PC_RESET;
      illegal <= 1'b0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      res     <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: if (mem.mem_ack) ir <= mem.mem_rdata[15:0];
        S_DECODE: begin
          a <= (ra == 4'd0) ? '0 : regs[ra];
          b <= (rb == 4'd0) ? '0 : regs[rb];
        end
        S_EXEC: begin
          res <= alu_res;
          if (!is_halt) pc <= pc_next;
          if (is_ill) illegal <= 1'b1;
        end
        S_MEM: if (mem.mem_ack && is_ld) res <= mem.mem_rdata;
        S_WB: if (rd != 4'd0) regs[rd] <= res;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/multicycle_core.md
# multicycle_core

Parametrised multi-cycle successor to the single-cycle 16-bit datapath and control top. It fetches fixed 16-bit instructions through one unified memory port with a req/ack handshake. Each instruction is sequenced through an explicit FSM, so the register width and the memory wait states are no longer tied to a single-cycle path. It sits at the top of the processor, between the system clock/reset and a shared instruction/data memory.

## Interface
Parameters:
- `DATA_W`, 16: register/ALU width; power of two, ≥16.
- `ADDR_W`, 16: word address width; ≤ `DATA_W`.
- `PC_RESET`, 0: PC value after reset.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; overrides every other input.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  `ADDR_W`  word address.
- `mem_wdata`  out  `DATA_W`  store data.
- `mem_rdata`  in  `DATA_W`  read data, valid in the ack cycle.
- `mem_ack`  in  1  transfer complete on this edge.
- `pc`  out  `ADDR_W`  current PC.
- `retire`  out  1  one-cycle pulse per completed instruction.
- `halted`  out  1  core stopped by HALT.
- `illegal`  out  1  sticky flag: an undefined opcode was executed.

## Operation
- Instruction fields: `op` = [3:0], `rd` = [7:4], `ra` = [11:8], `rb` = [15:12].
- Register file: 16 × `DATA_W`. R0 always reads 0; writes to R0 are discarded.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: rd = ra op rb, modulo 2^`DATA_W`.
  - 5 SHL, 6 SHR (logical): rd = ra shifted by R[rb][log2(`DATA_W`)-1:0].
  - 7 LDI: rd = zero-extended {instr[15:12], instr[11:8]}.
  - 8 LD: rd = mem[R[rb][`ADDR_W`-1:0]].
  - 9 ST: mem[R[rb][`ADDR_W`-1:0]] = R[ra].
  - 10 BEQ / 11 BNE: if the condition on R[ra], R[rb] holds, PC = PC+1+sext(rd); otherwise PC+1.
  - 12 JR: PC = R[ra][`ADDR_W`-1:0].
  - 13 HALT.
  - 14, 15: illegal. Executed as a NOP, sets `illegal`.
- PC arithmetic wraps modulo 2^`ADDR_W`. A fetched instruction is `mem_rdata[15:0]`.
- FSM states:
  - FETCH: `mem_req`=1, `mem_we`=0, `mem_addr`=PC. On ack, latch IR and go to DECODE.
  - DECODE: latch A = R[ra] and B = R[rb]. Go to EXEC.
  - EXEC: compute the ALU result and latch it. PC ← next PC (the branch/JR target, or PC+1).
    - LD/ST → MEM.
    - Register-writing ops → WB.
    - Branch, JR, illegal → FETCH.
    - HALT → HALT without advancing PC.
  - MEM: `mem_req`=1 with the address held. ST also drives `mem_we`=1 and `mem_wdata`=A. On ack, LD latches rdata and goes to WB; ST goes to FETCH.
  - WB: write rd. Go to FETCH.
  - HALT: terminal until `reset`; `halted`=1, `mem_req`=0.
- Handshake:
  - `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req`=1 and no ack has arrived.
  - `mem_ack` is ignored when `mem_req`=0.
  - `mem_req` drops the cycle after ack, because the state leaves FETCH/MEM.
- `retire` pulses in the final cycle of each instruction: WB, EXEC for branch/JR/illegal, MEM-ack for ST, and entry into HALT.

## Timing
- Reset values: PC=`PC_RESET`, all registers 0, state FETCH. All outputs 0 except `pc`.
- With zero-wait memory (ack in the request cycle):
  - ALU/LDI: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - Branch/JR/illegal: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- Reset asserted mid-transaction abandons the transfer. `mem_req` is 0 from the next edge, and memory must tolerate the abandoned request.
- A write to rd and a read of the same register by the next instruction needs no forwarding: DECODE always follows the previous WB.

## Configuration
- `MULTICYCLE_CORE_MUL_EN` defined: opcode 14 is MUL, rd = low `DATA_W` bits of ra×rb, 4 cycles, no `illegal`.
- Undefined: opcode 14 is illegal, and the multiplier is absent.

## Test plan
- Zero-wait memory, program LDI R1,0x12; LDI R2,0x34; ADD R3,R1,R2; HALT → R3=0x46. `retire` count 4. `halted`=1 at cycle 15; PC stays 3.
- ST R5→[R6=0x20] then LD R7←[0x20], with ack delayed 3 cycles on every request → R7=R5. Address/we/wdata stable through all waits. LD takes 8 cycles.
- BEQ with R1=R2, rd=0xF (−1), at PC 0x10 → next fetch at 0x10. BNE with unequal values at PC 0xFFFF, rd=1 → wraps to PC 0x0001.
- ADD with destination R0, then ADD R4,R0,R0 → R4=0. Opcode 15 → `illegal` set and held; PC advances by 1.
- Assert `reset` during a MEM wait → `mem_req`=0, PC=`PC_RESET` and all registers 0 after the edge. Fetch restarts at `PC_RESET`.
- With `MULTICYCLE_CORE_MUL_EN`, `DATA_W`=16: MUL of 0x0100×0x0100 → 0x0000. MUL of 0x00FF×0x0003 → 0x02FD. Without the macro, opcode 14 sets `illegal`.
